quantizer: RTL and testbench

QUANTIZER -- requirements
Module: quantizer

---
 rtl/lib_switchblock_pkg.sv | 16 +
 rtl/quantizer_sat_adder.sv | 34 +++
 rtl/quantizer.sv | 80 ++++++++
 tb/tb_quantizer.sv | 116 +++++++++++
 4 files changed

// File: rtl/lib_switchblock_pkg.sv
// ----------------------------------------------------------------------------
// lib_switchblock_pkg
// Shared constants for the quantizer datapath.
//   INPUT_WIDTH  : width of the input sample, feedback term and error output
//   OUTPUT_WIDTH : width of the quantized level code
//   QUANT_STEP   : weight of one quantizer level, in input units (power of 2)
//   MAX_LEVEL    : highest legal output code
// ----------------------------------------------------------------------------
package lib_switchblock_pkg;

    localparam int INPUT_WIDTH  = 16;
    localparam int OUTPUT_WIDTH = 4;
    localparam int QUANT_STEP   = 8192;
    localparam int MAX_LEVEL    = 8;

endpackage : lib_switchblock_pkg

// File: rtl/quantizer_sat_adder.sv
// ----------------------------------------------------------------------------
// sat_adder
// Adds an unsigned operand and a two's-complement operand and saturates the
// result to the unsigned range [0, 2^W-1]. Purely combinational.
//   a_i   : unsigned operand, W bits
//   b_i   : signed operand, W bits
//   sum_o : saturated unsigned sum, W bits
// ----------------------------------------------------------------------------
module sat_adder
    import lib_switchblock_pkg::*;
#(
    parameter int W = lib_switchblock_pkg::INPUT_WIDTH
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] sum_o
);

    // Two guard bits: one for carry out of the unsigned range, one for sign.
    logic [W+1:0] w_sum;

    assign w_sum = {2'b00, a_i} + {{2{b_i[W-1]}}, b_i};

    always_comb begin
        if (w_sum[W+1]) begin
            sum_o = '0;               // negative sum
        end else if (w_sum[W]) begin
            sum_o = '1;               // above 2^W-1
        end else begin
            sum_o = w_sum[W-1:0];
        end
    end

endmodule : sat_adder

// File: rtl/quantizer.sv
// ----------------------------------------------------------------------------
// quantizer
// Noise-shaped uniform quantizer. Adds the feedback term to the input sample
// with saturation, rounds half-up to the nearest level, clips to MAX_LEVEL and
// reports the signed quantization error. Both outputs are registered with a
// latency of one clock; a new sample is accepted every cycle.
//   clk_i           : clock, rising edge
//   rst_i           : asynchronous reset, active low
//   x_in_i          : unsigned input sample
//   ntf_in_i        : two's-complement noise-shaping feedback term
//   quantized_out_o : level code, 0..MAX_LEVEL
//   quant_error_o   : signed error, sat_sum - level*QUANT_STEP
// ----------------------------------------------------------------------------
module quantizer
    import lib_switchblock_pkg::*;
#(
    parameter int INPUT_WIDTH  = lib_switchblock_pkg::INPUT_WIDTH,
    parameter int OUTPUT_WIDTH = lib_switchblock_pkg::OUTPUT_WIDTH,
    parameter int QUANT_STEP   = lib_switchblock_pkg::QUANT_STEP,
    parameter int MAX_LEVEL    = lib_switchblock_pkg::MAX_LEVEL
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [INPUT_WIDTH-1:0]  x_in_i,
    input  logic [INPUT_WIDTH-1:0]  ntf_in_i,
    output logic [OUTPUT_WIDTH-1:0] quantized_out_o,
    output logic [INPUT_WIDTH-1:0]  quant_error_o
);

    localparam int SHIFT = $clog2(QUANT_STEP);

    logic [INPUT_WIDTH-1:0]  w_sat;
    logic [INPUT_WIDTH:0]    w_round;
    logic [INPUT_WIDTH:0]    w_level_raw;
    logic [OUTPUT_WIDTH-1:0] w_level;
    logic [INPUT_WIDTH-1:0]  w_recon;
    logic [INPUT_WIDTH-1:0]  w_error;

    logic [OUTPUT_WIDTH-1:0] r_level;
    logic [INPUT_WIDTH-1:0]  r_error;

    sat_adder #(
        .W (INPUT_WIDTH)
    ) u_sat_adder (
        .a_i   (x_in_i),
        .b_i   (ntf_in_i),
        .sum_o (w_sat)
    );

    // Round half-up: add half a step, then divide by the step with a shift.
    // One extra bit keeps the add from wrapping near full scale.
    assign w_round     = {1'b0, w_sat} + (INPUT_WIDTH+1)'(QUANT_STEP / 2);
    assign w_level_raw = w_round >> SHIFT;

    assign w_level = (w_level_raw > (INPUT_WIDTH+1)'(MAX_LEVEL))
                   ? OUTPUT_WIDTH'(MAX_LEVEL)
                   : w_level_raw[OUTPUT_WIDTH-1:0];

    // The error is bounded to [-QUANT_STEP/2, QUANT_STEP/2-1], so computing it
    // modulo 2^INPUT_WIDTH gives the exact two's-complement result even when
    // level*QUANT_STEP itself does not fit (e.g. 8*8192 = 65536).
    assign w_recon = INPUT_WIDTH'(w_level) << SHIFT;
    assign w_error = w_sat - w_recon;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_level <= '0;
            r_error <= '0;
        end else begin
            r_level <= w_level;
            r_error <= w_error;
        end
    end

    assign quantized_out_o = r_level;
    assign quant_error_o   = r_error;

endmodule : quantizer

// File: tb/tb_quantizer.sv
// ----------------------------------------------------------------------------
// tb_quantizer
// Directed self-checking bench for quantizer: reset behaviour, directed
// samples with hand-computed results, saturation and rounding boundaries,
// one-cycle latency and asynchronous mid-stream reset.
// ----------------------------------------------------------------------------
module tb_quantizer;

    logic        clk_i;
    logic        rst_i;
    logic [15:0] x_in_i;
    logic [15:0] ntf_in_i;
    logic [3:0]  quantized_out_o;
    logic [15:0] quant_error_o;

    int n_total = 0;
    int n_bad   = 0;

    quantizer dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .x_in_i          (x_in_i),
        .ntf_in_i        (ntf_in_i),
        .quantized_out_o (quantized_out_o),
        .quant_error_o   (quant_error_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [15:0] observed,
                         input logic [15:0] expected);
        n_total++;
        assert (observed === expected)
        else begin
            n_bad++;
            $error("FAIL %s: observed=%0d (0x%h) expected=%0d (0x%h)",
                   tag, observed, observed, expected, expected);
        end
    endtask

    // Drive a sample between edges, register it on the next rising edge and
    // sample the outputs 1 time unit later.
    task automatic apply(input logic [15:0] x, input logic [15:0] ntf);
        @(negedge clk_i);
        x_in_i   = x;
        ntf_in_i = ntf;
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_pair(input string tag, input logic [15:0] exp_out,
                              input int exp_err);
        check({tag, ".out"}, {12'd0, quantized_out_o}, exp_out);
        check({tag, ".err"}, quant_error_o, 16'(exp_err));
    endtask

    initial begin
        // Reset held low with a non-zero input: outputs stay 0 through edges.
        rst_i    = 1'b0;
        x_in_i   = 16'd1000;
        ntf_in_i = 16'd0;
        repeat (3) @(posedge clk_i);
        #1;
        check_pair("reset_hold", 16'd0, 0);

        // Release: first edge registers the current inputs (1000 -> 0, +1000).
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        check_pair("reset_release", 16'd0, 1000);

        apply(16'd0,     16'd0);     check_pair("zero",      16'd0, 0);
        apply(16'd32768, 16'd1024);  check_pair("mid",       16'd4, 1024);
        apply(16'd8191,  16'd512);   check_pair("step1",     16'd1, 511);
        apply(16'd12345, 16'd256);   check_pair("step2",     16'd2, -3783);
        apply(16'd65535, 16'd8192);  check_pair("sat_high",  16'd8, -1);
        apply(16'd16384, 16'd4096);  check_pair("half_up",   16'd3, -4096);
        apply(16'd100,   16'hFF38);  check_pair("sat_low",   16'd0, 0);
        apply(16'd4095,  16'd0);     check_pair("below_half", 16'd0, 4095);
        apply(16'd4096,  16'd0);     check_pair("at_half",   16'd1, -4096);

        // Latency: new inputs do not reach the outputs before the next edge.
        apply(16'd65535, 16'd0);     check_pair("full_scale", 16'd8, -1);
        @(negedge clk_i);
        x_in_i   = 16'd8192;
        ntf_in_i = 16'd0;
        #3;
        check_pair("hold_before_edge", 16'd8, -1);
        @(posedge clk_i);
        #1;
        check_pair("after_edge", 16'd1, 0);

        // Asynchronous mid-stream reset: clears between edges, in-flight
        // sample discarded, clock edges ignored while low.
        @(negedge clk_i);
        x_in_i   = 16'd40000;
        ntf_in_i = 16'd0;
        #2;
        rst_i = 1'b0;
        #1;
        check_pair("async_reset", 16'd0, 0);
        @(posedge clk_i);
        #1;
        check_pair("reset_edge_ignored", 16'd0, 0);

        @(negedge clk_i);
        rst_i = 1'b1;
        apply(16'd32768, 16'd1024);  check_pair("post_reset", 16'd4, 1024);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_quantizer
